// File: rtl/mac_accum_requant.sv
// Streaming signed MAC with saturating accumulator, bias add and rounding
// requantization shift; one 32-bit result per in_last-terminated vector.
module mac_accum_requant #(
  parameter int IN_W    = 16,
  parameter int ACC_W   = 32,
  parameter int SHIFT_W = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [IN_W-1:0]    in_act,
  input  logic signed [IN_W-1:0]    in_wgt,
  input  logic                      in_last,
  input  logic signed [ACC_W-1:0]   bias,
  input  logic        [SHIFT_W-1:0] shift,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [ACC_W-1:0]   out_acc
);

  localparam int T_W = ACC_W + 2;
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {ACC, DRAIN, OUT} state_t;

  state_t                    state, state_nx;
  logic                      started;
  logic [1:0]                drain_cnt;
  logic                      in_fire, last_fire, out_fire;

  logic signed [2*IN_W-1:0]  prod_full;
  logic signed [ACC_W-1:0]   prod;
  logic                      prod_vld;
  logic signed [ACC_W-1:0]   acc;
  logic signed [ACC_W:0]     sum;
  logic signed [ACC_W-1:0]   sum_sat;

  logic signed [ACC_W-1:0]   bias_q;
  logic        [SHIFT_W-1:0] shift_q;
  logic signed [T_W-1:0]     rnd;
  logic signed [T_W-1:0]     t;
  logic signed [T_W-1:0]     sh;
  logic signed [ACC_W-1:0]   req;

  assign in_fire   = in_valid && in_ready;
  assign last_fire = in_fire && in_last;
  assign out_fire  = out_valid && out_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ACC;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      ACC:     if (last_fire) state_nx = DRAIN;
      DRAIN:   if (drain_cnt == 2'd2) state_nx = OUT;
      OUT:     if (out_fire) state_nx = ACC;
      default: state_nx = ACC;
    endcase
  end

  // Output logic; in_ready stays low until the first edge after reset release
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      ACC:     in_ready  = started;
      DRAIN:   ;
      OUT:     out_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      started   <= 1'b0;
      drain_cnt <= '0;
    end else begin
      started   <= 1'b1;
      drain_cnt <= (state == DRAIN) ? drain_cnt + 2'd1 : '0;
    end
  end

  // Stage 1: full-width product register
  assign prod_full = in_act * in_wgt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod     <= '0;
      prod_vld <= 1'b0;
    end else begin
      prod_vld <= in_fire;
      if (in_fire) prod <= ACC_W'(prod_full);
    end
  end

  // Stage 2: one extra bit of headroom, then clamp on sign disagreement
  always_comb begin
    sum     = {acc[ACC_W-1], acc} + {prod[ACC_W-1], prod};
    sum_sat = sum[ACC_W-1:0];
    if (sum[ACC_W] != sum[ACC_W-1])
      sum_sat = sum[ACC_W] ? ACC_MIN : ACC_MAX;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        acc <= '0;
    else if (out_fire) acc <= '0;
    else if (prod_vld) acc <= sum_sat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bias_q  <= '0;
      shift_q <= '0;
    end else if (last_fire) begin
      bias_q  <= bias;
      shift_q <= shift;
    end
  end

  // Requantization: round half up, arithmetic shift, clamp back to ACC_W
  always_comb begin
    rnd = '0;
    if (shift_q != '0) rnd = T_W'(1) << (shift_q - SHIFT_W'(1));
    t   = {{2{acc[ACC_W-1]}}, acc} + {{2{bias_q[ACC_W-1]}}, bias_q} + rnd;
    sh  = t >>> shift_q;
    req = sh[ACC_W-1:0];
    if (!((&sh[T_W-1:ACC_W-1]) || !(|sh[T_W-1:ACC_W-1])))
      req = sh[T_W-1] ? ACC_MIN : ACC_MAX;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                   out_acc <= '0;
    else if (state == DRAIN && state_nx == OUT)   out_acc <= req;
  end

endmodule

// File: tb/tb_mac_accum_requant.sv
// Directed bench for mac_accum_requant: hand-computed dot products, rounding,
// saturation, backpressure and mid-vector reset.
module tb_mac_accum_requant;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] in_act;
  logic signed [15:0] in_wgt;
  logic               in_last;
  logic signed [31:0] bias;
  logic        [4:0]  shift;
  logic               out_valid;
  logic               out_ready;
  logic signed [31:0] out_acc;

  logic signed [15:0] va [0:7];
  logic signed [15:0] vw [0:7];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mac_accum_requant #(.IN_W(16), .ACC_W(32), .SHIFT_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_act(in_act), .in_wgt(in_wgt), .in_last(in_last),
    .bias(bias), .shift(shift),
    .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
    end
  endtask

  // Drive n beats; bias/shift carry junk except on the last beat
  task automatic send(input int n, input logic signed [31:0] b, input logic [4:0] s);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_act   = va[i];
      in_wgt   = vw[i];
      in_last  = (i == n - 1);
      if (i == n - 1) begin
        bias = b; shift = s;
      end else begin
        bias = 32'sd12345; shift = 5'd7;
      end
    end
  endtask

  // Wait for out_valid (bounded), check latency, value and in_ready low
  task automatic wait_result(input string tag, input logic signed [31:0] exp);
    int  cnt  = 0;
    bit  seen = 1'b0;
    while (!seen && cnt < 20) begin
      @(negedge clk);
      cnt++;
      in_valid = 1'b1;          // ignored while in_ready is low
      in_last  = 1'b1;
      in_act   = 16'sd777;
      in_wgt   = 16'sd777;
      bias     = -32'sd999;
      shift    = 5'd3;
      if (out_valid) seen = 1'b1;
    end
    in_valid = 1'b0;
    if (!seen) begin
      chk({tag, "_timeout"}, 32'(out_valid), 32'd1);
      return;
    end
    chk({tag, "_latency"}, 32'(cnt - 1), 32'd3);
    chk({tag, "_out_acc"}, out_acc, exp);
    chk({tag, "_in_ready_out"}, 32'(in_ready), 32'd0);
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    in_valid  = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_valid_after_hs"}, 32'(out_valid), 32'd0);
    chk({tag, "_ready_after_hs"}, 32'(in_ready), 32'd1);
  endtask

  task automatic run_vec(input string tag, input int n, input logic signed [31:0] b,
                         input logic [4:0] s, input logic signed [31:0] exp);
    send(n, b, s);
    wait_result(tag, exp);
    handshake(tag);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_act = '0; in_wgt = '0; in_last = 1'b0;
    bias = '0; shift = '0; out_ready = 1'b0;
    #3;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_acc",   out_acc, 32'd0);
    chk("rst_in_ready",  32'(in_ready), 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1 chk("ready_before_edge", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("ready_after_edge", 32'(in_ready), 32'd1);

    va[0] = 16'sd2;   vw[0] = 16'sd3;
    va[1] = -16'sd4;  vw[1] = 16'sd5;
    va[2] = 16'sd100; vw[2] = -16'sd1;
    run_vec("three_beat", 3, 32'sd10, 5'd0, -32'sd104);

    va[0] = 16'sd1000; vw[0] = 16'sd1000;
    run_vec("round_s4", 1, 32'sd0, 5'd4, 32'sd62500);
    run_vec("round_s5", 1, 32'sd0, 5'd5, 32'sd31250);

    for (int i = 0; i < 3; i++) begin
      va[i] = -16'sd32768; vw[i] = -16'sd32768;
    end
    run_vec("sat_pos", 3, 32'sd0, 5'd0, 32'sd2147483647);
    va[3] = -16'sd32768; vw[3] = 16'sd32767;
    run_vec("sat_pullback", 4, 32'sd0, 5'd0, 32'sd1073774591);

    va[0] = -16'sd7; vw[0] = 16'sd1;
    send(1, 32'sd0, 5'd0);
    wait_result("bp", -32'sd7);
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      in_last  = 1'b1;
      @(negedge clk);
      chk("bp_valid_hold", 32'(out_valid), 32'd1);
      chk("bp_acc_hold",   out_acc, -32'sd7);
      chk("bp_ready_low",  32'(in_ready), 32'd0);
    end
    handshake("bp");
    va[0] = 16'sd2; vw[0] = 16'sd3;
    run_vec("after_bp", 1, 32'sd0, 5'd0, 32'sd6);

    for (int i = 0; i < 4; i++) begin
      va[i] = 16'sd50; vw[i] = 16'sd50;
    end
    send(2, 32'sd0, 5'd0);
    @(negedge clk);
    in_valid = 1'b1; in_last = 1'b0; in_act = 16'sd50; in_wgt = 16'sd50;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_acc",   out_acc, 32'd0);
    chk("midrst_in_ready",  32'(in_ready), 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_ready_back", 32'(in_ready), 32'd1);
    va[0] = 16'sd5; vw[0] = 16'sd5;
    run_vec("after_rst", 1, 32'sd0, 5'd0, 32'sd25);

    va[0] = -16'sd3; vw[0] = 16'sd1;
    run_vec("neg_s1", 1, 32'sd0, 5'd1, -32'sd1);
    run_vec("neg_s2", 1, 32'sd0, 5'd2, -32'sd1);
    va[0] = -16'sd6;
    run_vec("neg6_s2", 1, 32'sd0, 5'd2, -32'sd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
